sgdmac_rd_ctrl: RTL and testbench

Read-side burst controller for the scatter-gather DMA engine. It turns one descriptor's source address and byte length into AXI read-address bursts and steers the returned read data into the data FIFO. Before each burst it reserves FIFO space as credit, so read data never arrives at a full FIFO. It sits between the descriptor fetch/dispatch logic and the AXI AR/R channels, upstream of the write-side controller that drains the same FIFO.

---
 rtl/sgdmac_pkg.sv | 26 ++
 rtl/sgdmac_rd_ctrl_if.sv | 34 +++
 rtl/sgdmac_burst_calc.sv | 29 ++
 rtl/sgdmac_rd_ctrl.sv | 141 ++++++++++++++
 tb/tb_sgdmac_rd_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sgdmac_pkg.sv
// Shared types and constants for the scatter-gather DMA engine.
// States, bytes-per-beat helper, 4 KB page size and AXI read response codes.
package sgdmac_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_ADDR  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Bytes per beat of the default 32-bit datapath.
  localparam int BPB         = 4;
  localparam int BOUNDARY_4K = 4096;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  function automatic int bytes_per_beat(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sgdmac_rd_ctrl_if.sv
// AXI AR/R channels plus the data-FIFO write port of the read controller.
// Signal suffixes are from the controller's point of view (master modport).
interface sgdmac_rd_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FREE_W     = 5
);

  // Every channel is valid/ready: a transfer happens on a rising clk edge where
  // both are high; the source holds valid and its payload stable until then.
  logic                  arvalid_o;
  logic                  arready_i;
  logic [ADDR_WIDTH-1:0] araddr_o;
  logic [3:0]            arlen_o;
  logic                  rvalid_i;
  logic                  rready_o;
  logic [DATA_WIDTH-1:0] rdata_i;
  logic [1:0]            rresp_i;
  logic                  rlast_i;
  logic [FREE_W-1:0]     fifo_free_i;
  logic                  fifo_wren_o;
  logic [DATA_WIDTH-1:0] fifo_wdata_o;

  modport master (
    output arvalid_o, araddr_o, arlen_o, rready_o, fifo_wren_o, fifo_wdata_o,
    input  arready_i, rvalid_i, rdata_i, rresp_i, rlast_i, fifo_free_i
  );

  modport slave (
    input  arvalid_o, araddr_o, arlen_o, rready_o, fifo_wren_o, fifo_wdata_o,
    output arready_i, rvalid_i, rdata_i, rresp_i, rlast_i, fifo_free_i
  );

endinterface

// File: rtl/sgdmac_burst_calc.sv
// Next burst length: min(remaining beats, MAX_BURST, beats left in the 4 KB page).
// Purely combinational; only the page offset of the address matters.
module sgdmac_burst_calc
  import sgdmac_pkg::*;
#(
  parameter int LEN_WIDTH      = 16,
  parameter int BYTES_PER_BEAT = 4,
  parameter int MAX_BURST      = 16,
  parameter int BLEN_W         = 5
) (
  input  logic [11:0]          page_off_i,
  input  logic [LEN_WIDTH-1:0] remaining_i,
  output logic [BLEN_W-1:0]    blen_o
);

  logic [31:0] to_bound;
  logic [31:0] cap;

  always_comb begin
    to_bound = (32'(BOUNDARY_4K) - {20'd0, page_off_i}) / 32'(BYTES_PER_BEAT);
    cap      = (32'(MAX_BURST) < to_bound) ? 32'(MAX_BURST) : to_bound;
    if (32'(remaining_i) < cap) begin
      blen_o = BLEN_W'(remaining_i);
    end else begin
      blen_o = BLEN_W'(cap);
    end
  end

endmodule

// File: rtl/sgdmac_rd_ctrl.sv
// Read-side burst controller: splits a descriptor into AXI read bursts, reserving
// FIFO credit before each one. Define SGDMAC_RD_OUTSTANDING_EN to allow overlap.
module sgdmac_rd_ctrl
  import sgdmac_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [LEN_WIDTH-1:0]  byte_len_i,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  err_o,
  output state_t                state_o,
  sgdmac_rd_ctrl_if.master      bus
);

  localparam int BYTES     = bytes_per_beat(DATA_WIDTH);
  localparam int BPB_SHIFT = $clog2(BYTES);
  localparam int FREE_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int BLEN_W    = $clog2(MAX_BURST) + 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [FREE_W-1:0]     reserved_q, reserved_d;
  logic [3:0]            arlen_q, arlen_d;
  logic                  err_q, err_d;

  logic [LEN_WIDTH-1:0]  beats_in;
  logic [BLEN_W-1:0]     blen_calc;
  logic [BLEN_W-1:0]     blen_cur;
  logic                  room;
  logic                  credit_ok;
  logic                  ar_hs;
  logic                  r_hs;

  sgdmac_burst_calc #(
    .LEN_WIDTH      (LEN_WIDTH),
    .BYTES_PER_BEAT (BYTES),
    .MAX_BURST      (MAX_BURST),
    .BLEN_W         (BLEN_W)
  ) u_burst_calc (
    .page_off_i  (addr_q[11:0]),
    .remaining_i (remaining_q),
    .blen_o      (blen_calc)
  );

  assign beats_in = byte_len_i >> BPB_SHIFT;
  assign blen_cur = BLEN_W'(arlen_q) + BLEN_W'(1);
  assign ar_hs    = (state_q == S_ADDR) && bus.arready_i;
  assign r_hs     = bus.rvalid_i && busy_o;

  // Free entries not yet promised to an issued burst must cover the new burst.
  assign room = 32'(bus.fifo_free_i) >= (32'(reserved_q) + 32'(blen_calc));
`ifdef SGDMAC_RD_OUTSTANDING_EN
  assign credit_ok = room;
`else
  assign credit_ok = room && (reserved_q == '0);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    arlen_d     = arlen_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d      = src_addr_i;
          remaining_d = beats_in;
          err_d       = 1'b0;
          state_d     = (beats_in == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (credit_ok) begin
          arlen_d = 4'(blen_calc - BLEN_W'(1));
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.arready_i) begin
          addr_d      = addr_q + (ADDR_WIDTH'(blen_cur) << BPB_SHIFT);
          remaining_d = remaining_q - LEN_WIDTH'(blen_cur);
          state_d     = (remaining_d != '0) ? S_CALC : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (reserved_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (r_hs && (bus.rresp_i != RRESP_OKAY)) err_d = 1'b1;
  end

  // A burst accept and a returning beat in one cycle net out to +blen-1.
  always_comb begin
    reserved_d = reserved_q;
    if (ar_hs) reserved_d = reserved_d + FREE_W'(blen_cur);
    if (r_hs)  reserved_d = reserved_d - FREE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      reserved_q  <= '0;
      arlen_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      reserved_q  <= reserved_d;
      arlen_q     <= arlen_d;
      err_q       <= err_d;
    end
  end

  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DONE);
  assign err_o            = err_q;
  assign state_o          = state_q;
  assign bus.arvalid_o    = (state_q == S_ADDR);
  assign bus.araddr_o     = addr_q;
  assign bus.arlen_o      = arlen_q;
  assign bus.rready_o     = busy_o;
  assign bus.fifo_wren_o  = bus.rvalid_i && bus.rready_o;
  assign bus.fifo_wdata_o = bus.rdata_i;

endmodule

// File: tb/tb_sgdmac_rd_ctrl.sv
// Bench for sgdmac_rd_ctrl: AXI read slave with addressed memory, a FIFO model
// fed by fifo_wren_o, and scoreboards for AR bursts and FIFO data.
module tb_sgdmac_rd_ctrl;
  import sgdmac_pkg::*;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int LW     = 16;
  localparam int DEPTH  = 16;
  localparam int FREE_W = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [LW-1:0] byte_len = '0;
  logic          done_o;
  logic          busy_o;
  logic          err_o;
  state_t        state_o;

  sgdmac_rd_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FREE_W(FREE_W)) bus ();

  sgdmac_rd_ctrl #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .LEN_WIDTH (LW),
    .FIFO_DEPTH (DEPTH), .MAX_BURST (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .src_addr_i (src_addr),
    .byte_len_i (byte_len),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .state_o    (state_o),
    .bus        (bus)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [AW+3:0] ar_exp_q[$];
  logic [DW-1:0] exp_q[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // stimulus knobs, written by the main sequence
  bit ar_rand   = 1'b0;
  bit ar_block  = 1'b0;
  bit r_rand    = 1'b0;
  bit hold_free = 1'b0;
  int hold_val  = 8;
  int drain_pct = 60;
  int err_beat  = -1;
  bit ar_seen   = 1'b0;
  int last_beat_cyc = -100;

  // ---------------- AXI slave + FIFO model ----------------
  initial begin
    logic [AW-1:0] r_addr;
    logic [AW+3:0] burst_q[$];
    logic [AW+3:0] b;
    logic [AW+3:0] ar_exp;
    logic [DW-1:0] d_exp;
    int r_left, occ, beat_no, err_due;
    bit wr_prev, dr_prev, stray;
    r_left = 0; occ = 0; beat_no = 0; err_due = -1;
    wr_prev = 1'b0; dr_prev = 1'b0;
    bus.arready_i = 1'b0; bus.rvalid_i = 1'b0; bus.rdata_i = '0;
    bus.rresp_i = RRESP_OKAY; bus.rlast_i = 1'b0; bus.fifo_free_i = FREE_W'(DEPTH);
    forever begin
      @(negedge clk);
      if (rst) begin
        r_left = 0;
        burst_q.delete();
      end
      occ = occ + int'(wr_prev) - int'(dr_prev);
      wr_prev = 1'b0;
      if (err_due == cyc) begin
        check_eq("err_rise", 64'(err_o), 64'(1));
        err_due = -1;
      end
      if (!busy_o) beat_no = 0;
      bus.fifo_free_i = hold_free ? FREE_W'(hold_val) : FREE_W'(DEPTH - occ);
      bus.arready_i   = ar_block ? 1'b0 : (ar_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (r_left == 0 && burst_q.size() > 0) begin
        b = burst_q.pop_front();
        r_addr = b[AW+3:4];
        r_left = int'(b[3:0]) + 1;
      end
      stray = 1'b0;
      if (r_left > 0 && (!r_rand || $urandom_range(0, 2) != 0)) begin
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = mem_word(r_addr);
        bus.rlast_i  = (r_left == 1);
        bus.rresp_i  = (beat_no == err_beat) ? RRESP_SLVERR : RRESP_OKAY;
      end else if (r_left == 0 && !busy_o) begin
        stray = 1'b1;
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = 32'hDEAD_BEEF;
        bus.rlast_i  = 1'b1;
        bus.rresp_i  = RRESP_DECERR;
      end else begin
        bus.rvalid_i = 1'b0;
        bus.rlast_i  = 1'b0;
        bus.rresp_i  = RRESP_OKAY;
      end
      #1;
      if (bus.arvalid_o) ar_seen = 1'b1;
      if (bus.arvalid_o && bus.arready_i) begin
        if (ar_exp_q.size() > 0) ar_exp = ar_exp_q.pop_front();
        else ar_exp = 'x;
        check_eq("ar_burst", {bus.araddr_o, bus.arlen_o}, ar_exp);
        burst_q.push_back({bus.araddr_o, bus.arlen_o});
      end
      if (stray) begin
        check_eq("stray_r", 64'(bus.fifo_wren_o), 64'(0));
      end else if (bus.fifo_wren_o) begin
        if (exp_q.size() > 0) d_exp = exp_q.pop_front();
        else d_exp = 'x;
        check_eq("fifo_data", bus.fifo_wdata_o, d_exp);
        check_eq("fifo_room", 64'(occ < DEPTH), 64'(1));
        if (bus.rresp_i != RRESP_OKAY) begin
          check_eq("err_pre", 64'(err_o), 64'(0));
          err_due = cyc + 1;
        end
        if (exp_q.size() == 0 && bus.rlast_i) last_beat_cyc = cyc;
        wr_prev = 1'b1;
        beat_no++;
        r_addr = r_addr + 4;
        r_left--;
      end
      dr_prev = (occ > 0) && ($urandom_range(0, 99) < drain_pct);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_beats(input logic [AW-1:0] addr, input int len);
    for (int i = 0; i < len / 4; i++) exp_q.push_back(mem_word(addr + AW'(4 * i)));
  endtask

  // Burst split: page-limited, at most 16 beats.
  task automatic push_split(input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] a;
    int rem, bl, to_pg;
    a = addr;
    rem = len / 4;
    while (rem > 0) begin
      to_pg = (4096 - int'(a[11:0])) / 4;
      bl = (rem > 16) ? 16 : rem;
      if (bl > to_pg) bl = to_pg;
      ar_exp_q.push_back({a, 4'(bl - 1)});
      a = a + AW'(bl * 4);
      rem -= bl;
    end
  endtask

  // Called at a negedge; returns one (or two, with chk_ar) negedges later.
  task automatic start_xfer(input logic [AW-1:0] addr, input int len, input bit chk_ar);
    start_i  = 1'b1;
    src_addr = addr;
    byte_len = LW'(len);
    @(negedge clk);
    start_i = 1'b0;
    check_eq("busy_lat", 64'(busy_o), 64'(1));
    check_eq("err_clear", 64'(err_o), 64'(0));
    if (chk_ar) begin
      @(negedge clk);
      check_eq("ar_lat", 64'(bus.arvalid_o), 64'(1));
    end
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    int k;
    k = 0;
    while (!done_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("done_seen", 64'(done_o), 64'(1));
    dcyc = cyc;
    @(negedge clk);
    check_eq("done_pulse", {62'd0, done_o, busy_o}, 64'(0));
    check_eq("ar_left", 64'(ar_exp_q.size()), 64'(0));
    check_eq("data_left", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dcyc, c0, len;
    logic [AW-1:0] addr;
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", {59'd0, done_o, busy_o, err_o, bus.arvalid_o, bus.rready_o}, 64'(0));
    check_eq("rst_ar", {bus.araddr_o, bus.arlen_o}, 64'(0));
    check_eq("rst_state", 64'(state_o), 64'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // single aligned burst
    ar_exp_q.push_back({32'h0000_1000, 4'd15});
    push_beats(32'h1000, 64);
    start_xfer(32'h1000, 64, 1'b1);
    wait_done(500, dcyc);
    check_eq("done_after_last", 64'(dcyc - last_beat_cyc), 64'(2));

    // 4 KB crossing; a start pulse mid-transfer must be ignored
    ar_exp_q.push_back({32'h0000_0FF0, 4'd3});
    ar_exp_q.push_back({32'h0000_1000, 4'd11});
    push_beats(32'h0FF0, 64);
    start_xfer(32'h0FF0, 64, 1'b1);
    @(negedge clk);
    start_i = 1'b1; src_addr = 32'h9000; byte_len = 16'd8;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(500, dcyc);
    check_eq("done_after_last", 64'(dcyc - last_beat_cyc), 64'(2));

    // insufficient credit holds off the first burst
    hold_free = 1'b1; hold_val = 8;
    push_split(32'h2000, 128);
    push_beats(32'h2000, 128);
    ar_seen = 1'b0;
    start_xfer(32'h2000, 128, 1'b0);
    repeat (20) @(negedge clk);
    check_eq("hold_no_ar", 64'(ar_seen), 64'(0));
    hold_free = 1'b0;
    wait_done(3000, dcyc);

    // zero length
    c0 = cyc;
    start_xfer(32'h5000, 0, 1'b0);
    wait_done(10, dcyc);
    check_eq("len0_done_lat", 64'((dcyc - c0) >= 1 && (dcyc - c0) <= 2), 64'(1));

    // error response on the second beat
    err_beat = 1;
    push_split(32'h6000, 16);
    push_beats(32'h6000, 16);
    start_xfer(32'h6000, 16, 1'b1);
    wait_done(500, dcyc);
    check_eq("err_sticky", 64'(err_o), 64'(1));
    err_beat = -1;

    // randomized transfers around page boundaries with back-pressure
    ar_rand = 1'b1; r_rand = 1'b1; drain_pct = 40;
    for (int t = 0; t < 6; t++) begin
      addr = 32'h0001_0000 + AW'($urandom_range(0, 3) << 12) + AW'($urandom_range(960, 1023) * 4);
      len  = $urandom_range(1, 48) * 4;
      push_split(addr, len);
      push_beats(addr, len);
      start_xfer(addr, len, 1'b0);
      wait_done(3000, dcyc);
      check_eq("done_after_last", 64'(dcyc - last_beat_cyc), 64'(2));
    end
    ar_rand = 1'b0; r_rand = 1'b0; drain_pct = 60;

    // reset while the address phase is stalled
    ar_block = 1'b1;
    start_xfer(32'h3000, 16, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_ctrl", {61'd0, busy_o, bus.arvalid_o, bus.rready_o}, 64'(0));
    check_eq("rst_mid_state", 64'(state_o), 64'(S_IDLE));
    rst = 1'b0;
    ar_block = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_idle", 64'(busy_o), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
